// File: rtl/scan_decoder.sv
// Registered N-to-2**N decoder with two modes: direct decode of an address,
// or an automatic scan that holds each output for dwell+1 cycles.
module scan_decoder #(
    parameter int N           = 2,
    parameter int DWELL_W     = 4,
    parameter int ACTIVE_HIGH = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               E,
    input  logic               mode,
    input  logic [N-1:0]       A,
    input  logic [DWELL_W-1:0] dwell,
    output logic [0:2**N-1]    D,
    output logic [N-1:0]       sel,
    output logic               wrap
);

    localparam int              NOUT      = 2 ** N;
    localparam logic            ACT_LVL   = (ACTIVE_HIGH != 0);
    localparam logic [0:NOUT-1] INACT_VEC = {NOUT{~ACT_LVL}};
    localparam logic [N-1:0]    LAST_SEL  = N'(NOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DIRECT,
        ST_SCAN
    } state_t;

    state_t             state_q, state_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic [N-1:0]       sel_q, sel_d;
    logic               wrap_q, wrap_d;
    logic [0:NOUT-1]    d_q, d_d;

    // Mode is re-evaluated every cycle; a scan only keeps its position while
    // the previous cycle was also a scan cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        wrap_d  = 1'b0;
        if (!E) begin
            state_d = ST_IDLE;
        end else if (!mode) begin
            state_d = ST_DIRECT;
            sel_d   = A;
            cnt_d   = '0;
        end else begin
            state_d = ST_SCAN;
            if (state_q != ST_SCAN) begin
                sel_d = '0;
                cnt_d = '0;
            end else if (cnt_q >= dwell) begin
                sel_d  = sel_q + 1'b1;
                cnt_d  = '0;
                wrap_d = (sel_q == LAST_SEL);
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Output pattern is decoded from the next-cycle index so D and sel
    // always change on the same edge.
    generate
        for (genvar gi = 0; gi < NOUT; gi++) begin : g_dec
            assign d_d[gi] = ((state_d != ST_IDLE) && (sel_d == N'(gi))) ? ACT_LVL : ~ACT_LVL;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            sel_q   <= '0;
            wrap_q  <= 1'b0;
            d_q     <= INACT_VEC;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            wrap_q  <= wrap_d;
            d_q     <= d_d;
        end
    end

    assign D    = d_q;
    assign sel  = sel_q;
    assign wrap = wrap_q;

endmodule
